// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit: tracks the two instructions ahead of decode (EX, MEM),
// registers per-operand forwarding selects for the instruction entering EX,
// and raises a combinational stall on a load-use dependency.
// Optional feature macro: HAZARD_STALL_COUNT_EN adds a 32-bit stall counter
// output o_StallCount.
module hazard_forward_unit #(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst,
  input  logic                  i_IdValid,
  input  logic [REG_ADDR_W-1:0] i_IdRs1,
  input  logic [REG_ADDR_W-1:0] i_IdRs2,
  input  logic                  i_IdUsesRs1,
  input  logic                  i_IdUsesRs2,
  input  logic [REG_ADDR_W-1:0] i_IdRd,
  input  logic                  i_IdRegWrite,
  input  logic                  i_IdIsLoad,
  input  logic                  i_Hold,
  input  logic                  i_Flush,
  output logic [1:0]            o_ForASel,
  output logic [1:0]            o_ForBSel,
  output logic                  o_Stall
`ifdef HAZARD_STALL_COUNT_EN
  ,
  output logic [31:0]           o_StallCount
`endif
);

  localparam logic [1:0] SEL_RF  = 2'd0;
  localparam logic [1:0] SEL_MEM = 2'd1;  // EX/MEM pipeline result
  localparam logic [1:0] SEL_WB  = 2'd2;  // MEM/WB pipeline result

  // EX tracking slot
  logic                  ex_valid_q, ex_valid_d;
  logic [REG_ADDR_W-1:0] ex_rd_q, ex_rd_d;
  logic                  ex_regwrite_q, ex_regwrite_d;
  logic                  ex_isload_q, ex_isload_d;

  // MEM tracking slot
  logic                  mem_valid_q, mem_valid_d;
  logic [REG_ADDR_W-1:0] mem_rd_q, mem_rd_d;
  logic                  mem_regwrite_q, mem_regwrite_d;
  logic                  mem_isload_q, mem_isload_d;

  logic [1:0] sel_a_q, sel_a_d;
  logic [1:0] sel_b_q, sel_b_d;

  logic ex_match_rs1, ex_match_rs2;
  logic mem_match_rs1, mem_match_rs2;
  logic bubble;

  function automatic logic slot_match(
    input logic                  valid,
    input logic                  regwrite,
    input logic [REG_ADDR_W-1:0] rd,
    input logic [REG_ADDR_W-1:0] rs,
    input logic                  uses
  );
    return valid & regwrite & (rd == rs) & (rs != '0) & uses;
  endfunction

  // Source-operand match against each in-flight producer
  always_comb begin
    ex_match_rs1  = slot_match(ex_valid_q, ex_regwrite_q, ex_rd_q, i_IdRs1, i_IdUsesRs1);
    ex_match_rs2  = slot_match(ex_valid_q, ex_regwrite_q, ex_rd_q, i_IdRs2, i_IdUsesRs2);
    mem_match_rs1 = slot_match(mem_valid_q, mem_regwrite_q, mem_rd_q, i_IdRs1, i_IdUsesRs1);
    mem_match_rs2 = slot_match(mem_valid_q, mem_regwrite_q, mem_rd_q, i_IdRs2, i_IdUsesRs2);
  end

  // Load-use stall; flush wins, and reset forces it low while slots clear
  always_comb begin
    o_Stall = i_IdValid & ~i_Flush & ~i_Rst & ex_isload_q &
              (ex_match_rs1 | ex_match_rs2);
  end

  // Next-state: slot advance, bubble insertion and newest-producer-wins selects
  always_comb begin
    bubble = i_Flush | o_Stall | ~i_IdValid;

    mem_valid_d    = ex_valid_q & ~i_Flush;
    mem_rd_d       = ex_rd_q;
    mem_regwrite_d = ex_regwrite_q;
    mem_isload_d   = ex_isload_q;

    ex_valid_d    = ~bubble;
    ex_rd_d       = i_IdRd;
    ex_regwrite_d = i_IdRegWrite & ~bubble;
    ex_isload_d   = i_IdIsLoad & ~bubble;

    sel_a_d = SEL_RF;
    sel_b_d = SEL_RF;
    if (!bubble) begin
      if (ex_match_rs1)       sel_a_d = SEL_MEM;
      else if (mem_match_rs1) sel_a_d = SEL_WB;
      if (ex_match_rs2)       sel_b_d = SEL_MEM;
      else if (mem_match_rs2) sel_b_d = SEL_WB;
    end
  end

  // Slot and select registers; reset overrides hold and flush
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      ex_valid_q     <= 1'b0;
      ex_rd_q        <= '0;
      ex_regwrite_q  <= 1'b0;
      ex_isload_q    <= 1'b0;
      mem_valid_q    <= 1'b0;
      mem_rd_q       <= '0;
      mem_regwrite_q <= 1'b0;
      mem_isload_q   <= 1'b0;
      sel_a_q        <= SEL_RF;
      sel_b_q        <= SEL_RF;
    end else if (!i_Hold) begin
      ex_valid_q     <= ex_valid_d;
      ex_rd_q        <= ex_rd_d;
      ex_regwrite_q  <= ex_regwrite_d;
      ex_isload_q    <= ex_isload_d;
      mem_valid_q    <= mem_valid_d;
      mem_rd_q       <= mem_rd_d;
      mem_regwrite_q <= mem_regwrite_d;
      mem_isload_q   <= mem_isload_d;
      sel_a_q        <= sel_a_d;
      sel_b_q        <= sel_b_d;
    end
  end

  assign o_ForASel = sel_a_q;
  assign o_ForBSel = sel_b_q;

`ifdef HAZARD_STALL_COUNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Count accepted stall cycles; wraps naturally at 32 bits
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (o_Stall && !i_Hold) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  // Stall counter register
  always_ff @(posedge i_Clk) begin
    if (i_Rst) stall_cnt_q <= '0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign o_StallCount = stall_cnt_q;
`endif

endmodule
